// File: rtl/scc_mem_pkg.sv
// ----------------------------------------------------------------------------
// scc_mem_pkg: shared types and constants for the scc memory responder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package scc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  // aw is log2 of the word count; anything above the last byte of the array is out of range
  function automatic logic [1:0] addr_errors(input logic [31:0] addr, input int unsigned aw);
    logic [1:0] errs;
    errs               = 2'b00;
    errs[ERR_MISALIGN] = (addr[1:0] != 2'b00);
    errs[ERR_RANGE]    = ((addr >> (aw + 2)) != 32'd0);
    return errs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scc_mem_responder_if.sv
// ----------------------------------------------------------------------------
// scc_mem_responder_if: core <-> memory responder fetch/load/store bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface scc_mem_responder_if;

  logic        halt_f;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_valid;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        busy;
  logic [1:0]  err_bits;

  modport master (
    output halt_f, instr_req, instr_addr, data_req, data_we, data_addr, data_wdata,
    input  instr_rdata, instr_valid, data_rdata, data_valid, busy, err_bits
  );

  modport slave (
    input  halt_f, instr_req, instr_addr, data_req, data_we, data_addr, data_wdata,
    output instr_rdata, instr_valid, data_rdata, data_valid, busy, err_bits
  );

endinterface

`default_nettype wire

// File: rtl/scc_mem_array.sv
// ----------------------------------------------------------------------------
// scc_mem_array: DEPTH x 32 single-port synchronous RAM, registered read. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scc_mem_array #(
  parameter int DEPTH = 256
) (
  input  wire logic                     clk,
  input  wire logic                     i_we,
  input  wire logic [$clog2(DEPTH)-1:0] i_addr,
  input  wire logic [31:0]              i_wdata,
  output logic      [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Contents deliberately survive reset, so neither the array nor the read register is reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/scc_mem_responder.sv
// ----------------------------------------------------------------------------
// scc_mem_responder: wait-state memory responder with fetch/data arbitration. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scc_mem_responder
  import scc_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input wire logic           clk,
  input wire logic           rst_n,
  scc_mem_responder_if.slave bus
);

  localparam int         AW          = $clog2(DEPTH);
  localparam logic [3:0] c_WAIT_LOAD = 4'((WAIT > 0) ? (WAIT - 1) : 0);

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_take_data;
  logic        w_take_instr;
  logic        w_resp;
  logic [1:0]  w_errs;
  logic [31:0] w_q;

  logic [3:0]  r_cnt;
  logic        r_port;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_instr_valid;
  logic        r_data_valid;
  logic        r_rd_ok;
  logic [1:0]  r_err;

  // A port whose response is showing this cycle still holds its req; do not re-accept it
  assign w_take_data  = bus.data_req  && !r_data_valid;
  assign w_take_instr = bus.instr_req && !r_instr_valid;
  assign w_resp       = (r_state == ST_RESP);
  assign w_errs       = addr_errors(r_addr, AW);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.halt_f) begin
          w_next = ST_HALTED;
        end else if (w_take_data || w_take_instr) begin
          w_accept = 1'b1;
          w_next   = (WAIT > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP:   w_next = bus.halt_f ? ST_HALTED : ST_IDLE;
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= 4'd0;
      r_port        <= PORT_INSTR;
      r_we          <= 1'b0;
      r_addr        <= 32'd0;
      r_wdata       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      r_rd_ok       <= 1'b0;
      r_err         <= 2'b00;
    end else begin
      if (w_accept) begin
        r_port  <= w_take_data ? PORT_DATA : PORT_INSTR;
        r_addr  <= w_take_data ? bus.data_addr : bus.instr_addr;
        r_we    <= w_take_data && bus.data_we;
        r_wdata <= bus.data_wdata;
        r_cnt   <= c_WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Valid is registered from RESP so it lines up with the registered RAM read
      r_instr_valid <= w_resp && (r_port == PORT_INSTR);
      r_data_valid  <= w_resp && (r_port == PORT_DATA);
      r_rd_ok       <= w_resp && !r_we && (w_errs == 2'b00);
      if (w_resp) begin
        r_err <= r_err | w_errs;
      end
    end
  end

  scc_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_resp && r_we && (w_errs == 2'b00)),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_q)
  );

  assign bus.instr_valid = r_instr_valid;
  assign bus.data_valid  = r_data_valid;
  assign bus.instr_rdata = (r_instr_valid && r_rd_ok) ? w_q : 32'd0;
  assign bus.data_rdata  = (r_data_valid  && r_rd_ok) ? w_q : 32'd0;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.err_bits    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_scc_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_scc_mem_responder: directed plus randomized checks against a word-array model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_scc_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAIT  = 2;
  localparam int LAT   = WAIT + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];
  logic [1:0]  exp_err;

  scc_mem_responder_if bus ();

  scc_mem_responder #(
    .DEPTH (DEPTH),
    .WAIT  (WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_errs(input logic [31:0] addr);
    logic [1:0] e;
    e[0] = (addr % 4) != 0;
    e[1] = addr >= 32'(4 * DEPTH);
    return e;
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  task automatic txn(input bit is_data, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input string tag);
    logic [1:0]  e;
    logic [31:0] exp_rd;
    logic [31:0] rd;
    int          lat;
    bit          seen;
    e      = model_errs(addr);
    exp_rd = (we || (e != 2'b00)) ? 32'd0 : model_mem[model_idx(addr)];
    if (is_data) begin
      bus.data_req   = 1'b1;
      bus.data_we    = we;
      bus.data_addr  = addr;
      bus.data_wdata = wd;
    end else begin
      bus.instr_req  = 1'b1;
      bus.instr_addr = addr;
    end
    seen = 1'b0;
    lat  = 0;
    rd   = 32'd0;
    while (!seen && lat < 50) begin
      tick();
      lat++;
      seen = is_data ? bus.data_valid  : bus.instr_valid;
      rd   = is_data ? bus.data_rdata  : bus.instr_rdata;
    end
    bus.instr_req = 1'b0;
    bus.data_req  = 1'b0;
    check($sformatf("%s latency", tag), 32'(lat), 32'(LAT));
    if (seen) begin
      check($sformatf("%s rdata", tag), rd, exp_rd);
    end
    if (we && (e == 2'b00)) begin
      model_mem[model_idx(addr)] = wd;
    end
    exp_err = exp_err | e;
    tick();
    check($sformatf("%s pulse width", tag), 32'(is_data ? bus.data_valid : bus.instr_valid), 32'd0);
    check($sformatf("%s err_bits", tag), 32'(bus.err_bits), 32'(exp_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    exp_err = 2'b00;
    tick();
  endtask

  initial begin
    int          dcyc;
    int          icyc;
    int          nvalid;
    logic [31:0] drd;
    logic [31:0] ird;
    logic [31:0] wd;
    bit          is_d;
    bit          we;

    bus.halt_f     = 1'b0;
    bus.instr_req  = 1'b0;
    bus.instr_addr = 32'd0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_addr  = 32'd0;
    bus.data_wdata = 32'd0;
    exp_err        = 2'b00;

    tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset instr_valid", 32'(bus.instr_valid), 32'd0);
    check("reset data_valid", 32'(bus.data_valid), 32'd0);
    check("reset err_bits", 32'(bus.err_bits), 32'd0);
    check("reset data_rdata", bus.data_rdata, 32'd0);
    check("reset instr_rdata", bus.instr_rdata, 32'd0);
    do_reset();

    // Preload word 3 and word 4 through the store path
    txn(1'b1, 1'b1, 32'h0C, 32'hDEADBEEF, "preload w3");
    txn(1'b1, 1'b1, 32'h10, 32'hA5A50010, "preload w4");
    txn(1'b0, 1'b0, 32'h0C, 32'd0, "basic fetch");
    check("basic fetch model", model_mem[3], 32'hDEADBEEF);

    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0C;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b0;
    bus.data_addr  = 32'h10;
    dcyc = 0;
    icyc = 0;
    drd  = 32'd0;
    ird  = 32'd0;
    for (int c = 1; c <= 40 && (dcyc == 0 || icyc == 0); c++) begin
      tick();
      if (bus.data_valid && dcyc == 0) begin
        dcyc          = c;
        drd           = bus.data_rdata;
        bus.data_req  = 1'b0;
      end
      if (bus.instr_valid && icyc == 0) begin
        icyc          = c;
        ird           = bus.instr_rdata;
        bus.instr_req = 1'b0;
      end
    end
    bus.instr_req = 1'b0;
    bus.data_req  = 1'b0;
    check("arb data cycle", 32'(dcyc), 32'(LAT));
    check("arb instr cycle", 32'(icyc), 32'(2 * LAT));
    check("arb data rdata", drd, model_mem[4]);
    check("arb instr rdata", ird, model_mem[3]);
    tick();

    txn(1'b1, 1'b1, 32'h20, 32'h12345678, "store 0x20");
    txn(1'b1, 1'b0, 32'h20, 32'd0, "load 0x20");
    check("store-load model", model_mem[8], 32'h12345678);

    for (int i = 0; i < 32; i++) begin
      txn(1'b1, 1'b1, 32'(i * 4), $urandom, "rand preload");
    end
    for (int i = 0; i < 40; i++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d && 1'($urandom_range(0, 1));
      wd   = $urandom;
      txn(is_d, we, 32'($urandom_range(0, 31) * 4), wd, "rand op");
    end

    txn(1'b1, 1'b0, 32'h02, 32'd0, "misaligned load");
    check("misaligned err", 32'(bus.err_bits), 32'b01);
    txn(1'b1, 1'b1, 32'h400, 32'hFFFFFFFF, "range store");
    check("range err", 32'(bus.err_bits), 32'b11);
    txn(1'b1, 1'b0, 32'h00, 32'd0, "word0 intact");

    // Abort a store while it sits in WAIT
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.data_addr  = 32'h20;
    bus.data_wdata = 32'hBAD0BAD0;
    tick();
    check("abort busy in wait", 32'(bus.busy), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort data_valid", 32'(bus.data_valid), 32'd0);
    check("abort err_bits", 32'(bus.err_bits), 32'd0);
    check("abort data_rdata", bus.data_rdata, 32'd0);
    tick();
    bus.data_req = 1'b0;
    rst_n        = 1'b1;
    exp_err      = 2'b00;
    nvalid       = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.data_valid || bus.instr_valid) nvalid++;
    end
    check("abort no valid", 32'(nvalid), 32'd0);
    txn(1'b1, 1'b0, 32'h20, 32'd0, "abort word kept");

    // Halt raised mid-WAIT: the fetch still completes, then everything is ignored
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0C;
    tick();
    tick();
    bus.halt_f = 1'b1;
    icyc = 2;
    ird  = 32'd0;
    while (!bus.instr_valid && icyc < 50) begin
      tick();
      icyc++;
    end
    ird           = bus.instr_rdata;
    bus.instr_req = 1'b0;
    check("halt fetch latency", 32'(icyc), 32'(LAT));
    check("halt fetch rdata", ird, model_mem[3]);
    tick();
    check("halted busy", 32'(bus.busy), 32'd1);
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = 32'h0C;
    bus.instr_req = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.data_valid || bus.instr_valid) nvalid++;
    end
    check("halted no valid", 32'(nvalid), 32'd0);
    check("halted still busy", 32'(bus.busy), 32'd1);
    bus.data_req  = 1'b0;
    bus.instr_req = 1'b0;
    bus.halt_f    = 1'b0;
    do_reset();
    check("post-halt reset busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scc_mem_responder.md
# scc_mem_responder

Memory-side responder for the single-cycle core's fetch/load/store interface. It serves instruction-fetch and data read/write requests from one single-ported word array, adds a configurable number of wait states, arbitrates between the two request ports, flags bad addresses, and freezes cleanly on halt. It sits between the core and its backing storage. It replaces the zero-latency combinational memory model, so the core can be exercised against realistic latency.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- WAIT, 1: extra cycles between acceptance and response; range 0 to 15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- halt_f  in  1  core has executed HALT.
- instr_req  in  1  fetch request; held high until instr_valid.
- instr_addr  in  32  byte address of the fetch.
- instr_rdata  out  32  fetched word; meaningful only while instr_valid is high.
- instr_valid  out  1  one-cycle fetch-response pulse.
- data_req  in  1  data request; held high until data_valid.
- data_we  in  1  1 = store, 0 = load; sampled at acceptance.
- data_addr  in  32  byte address; sampled at acceptance.
- data_wdata  in  32  store data; sampled at acceptance.
- data_rdata  out  32  load result; meaningful only while data_valid is high.
- data_valid  out  1  one-cycle data-response pulse.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_bits  out  2  sticky error flags: bit0 = misaligned access, bit1 = out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP, HALTED.
- **IDLE, halt_f = 1:** go to HALTED; no request is accepted.
- **IDLE, data_req = 1:** accept the data request.
- **IDLE, instr_req = 1 only:** accept the fetch request.
- **Arbitration:** data wins when both requests are high in the same cycle. The fetch stays pending, because the requester holds instr_req, and is accepted in the first IDLE cycle after the data response.
- **Acceptance:** latch the port id, address, we and wdata. Go to WAIT if WAIT > 0, else to RESP.
- **WAIT:** a counter loads WAIT-1 at acceptance and decrements each cycle; move to RESP when it reaches 0.
- **RESP:**
  - Assert the matching valid for exactly one cycle with the read data.
  - A store commits its write in this cycle; a store returns data_rdata = 0.
  - Next state: HALTED if halt_f = 1, else IDLE.
- **HALTED:** terminal. Requests are ignored, valid outputs stay 0, and only rst exits.
- **halt_f during WAIT:** the in-flight transaction still completes and responds, then the FSM enters HALTED.
- **Address checks:**
  - Word index = addr[log2(DEPTH)+1:2].
  - addr[1:0] != 0 sets err_bits[0].
  - addr >= 4*DEPTH sets err_bits[1].
  - An erroring access still completes and pulses valid with rdata = 0. Stores with errors do not write.
  - Both bits can set on the same access.
- **err_bits:** cleared only by reset.

## Timing
- Request accepted at edge N; valid is high in the cycle following edge N+1+WAIT. With WAIT = 0 the response arrives on the next cycle.
- Back-to-back throughput: one transaction per WAIT+2 cycles, because IDLE costs one cycle between transactions.
- **Reset values:** all outputs 0, FSM in IDLE, counter 0.
- **Reset mid-transaction:** the transaction is aborted, no write commits, and no valid is produced after rst deasserts.
- **Array contents:** not cleared by reset.
- **Read path:** the array read is registered. Reading the same word in the cycle after a store returns the new data.

## Structure
- Package scc_mem_pkg holds:
  - the state enum;
  - port-id constants PORT_INSTR = 0 and PORT_DATA = 1;
  - the err_bits index constants ERR_MISALIGN = 0 and ERR_RANGE = 1.
- Sub-module scc_mem_array: DEPTH x 32 single-port synchronous RAM with one write enable and a registered read.
- Top level holds the FSM, arbiter, wait counter, request latches and error logic.

## Test plan
- **Basic fetch:** WAIT = 2, preload word 3 = 0xDEADBEEF; fetch 0x0C -> instr_valid for one cycle, 4 cycles after the request edge, with instr_rdata = 0xDEADBEEF.
- **Arbitration:** instr_req and data_req rise together with a load of 0x10 -> data_valid first; instr_valid follows WAIT+2 cycles later.
- **Store then load:** store 0x12345678 to 0x20, then load 0x20 -> data_rdata = 0x12345678; data_rdata = 0 on the store response.
- **Errors:** load 0x02 -> err_bits = 01 and rdata = 0. Store to 0x400 with DEPTH = 256 -> err_bits = 11; word 0 is unchanged.
- **Halt:** halt_f rises during WAIT -> the pending response is still delivered, the FSM goes to HALTED, and later requests get no valid.
- **Reset mid-transaction:** rst low during WAIT of a store -> outputs are 0 immediately and the target word keeps its old value.
